// File: rtl/sme_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : sme_pkg                                                 |
// | Purpose  : Shared definitions for the string-match-engine driver:  |
// |            FSM state encoding, default buffer depths and timeout,  |
// |            and a small elaboration-time helper.                    |
// | Ports    : none (package)                                          |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package sme_pkg;

  localparam int STR_MAX_DEF = 32;
  localparam int PAT_MAX_DEF = 8;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_STR = 3'd1,
    ST_SEND_PAT = 3'd2,
    ST_WAIT     = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sme_char_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : sme_char_buf                                            |
// | Purpose  : Append-only character buffer with indexed read.         |
// | Ports    : clk, reset (async, active-low)                          |
// |            clr_i     - empty the buffer (wins over wr_i)           |
// |            wr_i      - append wdata_i when not full                |
// |            rd_idx_i  - read index; reads past len return 8'h00     |
// |            rd_data_o - character at rd_idx_i                       |
// |            len_o     - number of stored characters                 |
// |            full_o    - len_o == DEPTH                              |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module sme_char_buf
  import sme_pkg::*;
#(
  parameter int DEPTH = STR_MAX_DEF,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [7:0]    wdata_i,
  input  logic [LW-1:0] rd_idx_i,
  output logic [7:0]    rd_data_o,
  output logic [LW-1:0] len_o,
  output logic          full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem_q [DEPTH];
  logic [LW-1:0] len_q;

  assign full_o    = (len_q == LW'(DEPTH));
  assign len_o     = len_q;
  // Guarding on len keeps stale characters from a previous fill invisible.
  assign rd_data_o = (rd_idx_i < len_q) ? mem_q[rd_idx_i[AW-1:0]] : 8'h00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q <= '0;
    end else if (clr_i) begin
      len_q <= '0;
    end else if (wr_i && !full_o) begin
      len_q <= len_q + LW'(1);
    end
  end

  // Storage needs no reset: contents are only visible below len_q.
  always_ff @(posedge clk) begin
    if (wr_i && !full_o && !clr_i) begin
      mem_q[len_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sme_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : sme_driver                                              |
// | Purpose  : Loads a string and a pattern into local buffers, then   |
// |            streams them to a match engine and captures its result  |
// |            (or a timeout).                                         |
// | Ports    : clk, reset (async, active-low)                          |
// |            wr_str/wr_pat/wdata/buf_clr - buffer loading (IDLE only)|
// |            start/send_str              - job request               |
// |            valid/match/match_index     - engine result             |
// |            chardata/isstring/ispattern - character stream          |
// |            busy/done                   - job status                |
// |            res_match/res_index/res_timeout - captured result       |
// |            err                         - sticky error flag         |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module sme_driver
  import sme_pkg::*;
#(
  parameter int STR_MAX = STR_MAX_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_str,
  input  logic       wr_pat,
  input  logic [7:0] wdata,
  input  logic       buf_clr,
  input  logic       start,
  input  logic       send_str,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  output logic       busy,
  output logic       done,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout,
  output logic       err
);

  // One index counter serves both buffers, so it is sized for the larger.
  localparam int IW = $clog2(max_int(STR_MAX, PAT_MAX) + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] wait_cnt_q;
  logic [7:0]    chardata_q;
  logic          isstring_q;
  logic          ispattern_q;
  logic          busy_q;
  logic          done_q;
  logic          res_match_q;
  logic [4:0]    res_index_q;
  logic          res_timeout_q;
  logic          err_q;

  logic          idle;
  logic          str_wr;
  logic          pat_wr;
  logic          str_full;
  logic          pat_full;
  logic          wr_overflow;
  logic          start_ok;
  logic [IW-1:0] str_len;
  logic [IW-1:0] pat_len;
  logic [IW-1:0] str_rd_idx;
  logic [IW-1:0] pat_rd_idx;
  logic [7:0]    str_rd;
  logic [7:0]    pat_rd;

  assign idle        = (state_q == ST_IDLE);
  assign str_wr      = idle && wr_str && !buf_clr;
  assign pat_wr      = idle && wr_pat && !buf_clr;
  assign wr_overflow = (str_wr && str_full) || (pat_wr && pat_full);
  assign start_ok    = (pat_len != '0) && (!send_str || (str_len != '0));

  // Outside its own send state each buffer is addressed at 0, so the first
  // character is ready on the edge that enters that state.
  assign str_rd_idx  = (state_q == ST_SEND_STR) ? idx_q : '0;
  assign pat_rd_idx  = (state_q == ST_SEND_PAT) ? idx_q : '0;

  sme_char_buf #(.DEPTH(STR_MAX), .LW(IW)) u_str_buf (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (idle && buf_clr),
    .wr_i     (str_wr),
    .wdata_i  (wdata),
    .rd_idx_i (str_rd_idx),
    .rd_data_o(str_rd),
    .len_o    (str_len),
    .full_o   (str_full)
  );

  sme_char_buf #(.DEPTH(PAT_MAX), .LW(IW)) u_pat_buf (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (idle && buf_clr),
    .wr_i     (pat_wr),
    .wdata_i  (wdata),
    .rd_idx_i (pat_rd_idx),
    .rd_data_o(pat_rd),
    .len_o    (pat_len),
    .full_o   (pat_full)
  );

  // idx_q counts characters already driven in the current send state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      wait_cnt_q    <= '0;
      chardata_q    <= 8'h00;
      isstring_q    <= 1'b0;
      ispattern_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      res_match_q   <= 1'b0;
      res_index_q   <= 5'd0;
      res_timeout_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr_overflow) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (start_ok) begin
              res_timeout_q <= 1'b0;
              busy_q        <= 1'b1;
              idx_q         <= IW'(1);
              if (send_str) begin
                state_q    <= ST_SEND_STR;
                chardata_q <= str_rd;
                isstring_q <= 1'b1;
              end else begin
                state_q     <= ST_SEND_PAT;
                chardata_q  <= pat_rd;
                ispattern_q <= 1'b1;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_SEND_STR: begin
          if (idx_q == str_len) begin
            state_q     <= ST_SEND_PAT;
            chardata_q  <= pat_rd;
            isstring_q  <= 1'b0;
            ispattern_q <= 1'b1;
            idx_q       <= IW'(1);
          end else begin
            chardata_q <= str_rd;
            idx_q      <= idx_q + IW'(1);
          end
        end
        ST_SEND_PAT: begin
          if (idx_q == pat_len) begin
            state_q     <= ST_WAIT;
            chardata_q  <= 8'h00;
            ispattern_q <= 1'b0;
            idx_q       <= '0;
            wait_cnt_q  <= '0;
          end else begin
            chardata_q <= pat_rd;
            idx_q      <= idx_q + IW'(1);
          end
        end
        ST_WAIT: begin
          if (valid) begin
            res_match_q <= match;
            res_index_q <= match_index;
            done_q      <= 1'b1;
            state_q     <= ST_DONE;
          end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
            res_timeout_q <= 1'b1;
            res_match_q   <= 1'b0;
            done_q        <= 1'b1;
            state_q       <= ST_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + TW'(1);
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign chardata    = chardata_q;
  assign isstring    = isstring_q;
  assign ispattern   = ispattern_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign res_match   = res_match_q;
  assign res_index   = res_index_q;
  assign res_timeout = res_timeout_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sme_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_sme_driver                                           |
// | Purpose  : Self-checking bench for sme_driver with a queue-based   |
// |            reference model of the buffers and job results.         |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_sme_driver;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int TIMEOUT = 64;

  logic       clk;
  logic       reset;
  logic       wr_str;
  logic       wr_pat;
  logic [7:0] wdata;
  logic       buf_clr;
  logic       start;
  logic       send_str;
  logic       valid;
  logic       match;
  logic [4:0] match_index;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       busy;
  logic       done;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_timeout;
  logic       err;

  sme_driver #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_str     (wr_str),
    .wr_pat     (wr_pat),
    .wdata      (wdata),
    .buf_clr    (buf_clr),
    .start      (start),
    .send_str   (send_str),
    .valid      (valid),
    .match      (match),
    .match_index(match_index),
    .chardata   (chardata),
    .isstring   (isstring),
    .ispattern  (ispattern),
    .busy       (busy),
    .done       (done),
    .res_match  (res_match),
    .res_index  (res_index),
    .res_timeout(res_timeout),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [7:0] str_m[$];
  logic [7:0] pat_m[$];
  logic       err_m;
  logic [4:0] res_idx_m;

  // Observations of the last job
  logic [7:0] obs_s[$];
  logic [7:0] obs_p[$];
  int         obs_done;
  int         obs_lat;
  int         obs_excl;
  int         obs_zero;
  int         obs_busy;
  logic       obs_idle;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int seq_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
    int n;
    n = 0;
    if (a.size() != b.size()) return -1;
    foreach (a[i]) if (a[i] !== b[i]) n++;
    return n;
  endfunction

  function automatic int find_pat();
    bit ok;
    for (int i = 0; i + pat_m.size() <= str_m.size(); i++) begin
      ok = 1'b1;
      for (int j = 0; j < pat_m.size(); j++) if (str_m[i+j] !== pat_m[j]) ok = 1'b0;
      if (ok) return i;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    wr_str = 0; wr_pat = 0; wdata = 0; buf_clr = 0; start = 0; send_str = 0;
    valid = 0; match = 0; match_index = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    str_m.delete(); pat_m.delete(); err_m = 1'b0; res_idx_m = 5'd0;
  endtask

  task automatic put_str(input logic [7:0] c);
    wr_str = 1'b1; wdata = c;
    tick();
    wr_str = 1'b0;
    if (str_m.size() < STR_MAX) str_m.push_back(c); else err_m = 1'b1;
  endtask

  task automatic put_pat(input logic [7:0] c);
    wr_pat = 1'b1; wdata = c;
    tick();
    wr_pat = 1'b0;
    if (pat_m.size() < PAT_MAX) pat_m.push_back(c); else err_m = 1'b1;
  endtask

  // Clear with random simultaneous writes: the clear must win.
  task automatic clr_bufs();
    buf_clr = 1'b1; wr_str = 1'($urandom_range(0, 1)); wr_pat = 1'($urandom_range(0, 1));
    wdata = 8'($urandom);
    tick();
    buf_clr = 1'b0; wr_str = 1'b0; wr_pat = 1'b0;
    str_m.delete(); pat_m.delete();
  endtask

  // Drives one job and records what the DUT streamed; valid arrives
  // 'delay' cycles after the last pattern character (never if > TIMEOUT).
  task automatic run_job(input bit s, input int delay, input bit m, input logic [4:0] mi);
    int wj;
    bit seen_p;
    obs_s.delete(); obs_p.delete();
    obs_done = 0; obs_lat = -1; obs_excl = 0; obs_zero = 0; obs_busy = 0;
    wj = -1; seen_p = 1'b0;
    start = 1'b1; send_str = s;
    tick();
    start = 1'b0; send_str = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (isstring && ispattern) obs_excl++;
      if (!isstring && !ispattern && chardata !== 8'h00) obs_zero++;
      if (busy !== 1'b1) obs_busy++;
      if (isstring) obs_s.push_back(chardata);
      if (ispattern) begin
        obs_p.push_back(chardata);
        seen_p = 1'b1;
      end else if (seen_p && wj < 0) begin
        wj = 0;
      end
      if (done) begin
        obs_done++;
        obs_lat = wj;
        break;
      end
      valid = 1'b0; match = 1'b0; match_index = 5'd0;
      if (wj >= 0) begin
        if (wj + 1 == delay) begin
          valid = 1'b1; match = m; match_index = mi;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        valid = 1'b1; match = 1'($urandom_range(0, 1)); match_index = 5'($urandom);
      end
      tick();
      if (wj >= 0) wj++;
    end
    valid = 1'b0; match = 1'b0; match_index = 5'd0;
    tick();
    if (done) obs_done++;
    obs_idle = !busy;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({chardata, isstring, ispattern, busy, done} !== 12'h000) begin
      errors++;
      $display("FAIL reset_stream got %h want 000", {chardata, isstring, ispattern, busy, done});
    end
    checks++;
    if ({res_match, res_index, res_timeout, err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_result got %h want 00", {res_match, res_index, res_timeout, err});
    end
  endtask

  task automatic test_basic();
    logic [7:0] es[$];
    clr_bufs();
    put_str(8'h61); put_str(8'h62); put_pat(8'h62);
    run_job(1'b1, 3, 1'b1, 5'd1);
    es = '{8'h61, 8'h62};
    checks++;
    if (seq_diff(obs_s, es) != 0) begin
      errors++; $display("FAIL basic_str got %p want %p", obs_s, es);
    end
    es = '{8'h62};
    checks++;
    if (seq_diff(obs_p, es) != 0) begin
      errors++; $display("FAIL basic_pat got %p want %p", obs_p, es);
    end
    checks++;
    if ({res_match, res_index, res_timeout} !== {1'b1, 5'd1, 1'b0}) begin
      errors++; $display("FAIL basic_result got m=%b i=%0d t=%b want m=1 i=1 t=0", res_match, res_index, res_timeout);
    end
    checks++;
    if (obs_done != 1 || !obs_idle || obs_busy != 0) begin
      errors++; $display("FAIL basic_done got pulses=%0d idle=%b busylow=%0d want 1 1 0", obs_done, obs_idle, obs_busy);
    end
    res_idx_m = 5'd1;
  endtask

  task automatic test_pattern_only();
    clr_bufs();
    for (int i = 0; i < 3; i++) put_pat(8'($urandom_range(97, 99)));
    run_job(1'b0, 4, 1'b0, 5'd3);
    checks++;
    if (obs_s.size() != 0) begin
      errors++; $display("FAIL patonly_isstring got %0d cycles want 0", obs_s.size());
    end
    checks++;
    if (seq_diff(obs_p, pat_m) != 0) begin
      errors++; $display("FAIL patonly_pat got %p want %p", obs_p, pat_m);
    end
    checks++;
    if (obs_done != 1 || res_match !== 1'b0 || res_index !== 5'd3) begin
      errors++; $display("FAIL patonly_result got pulses=%0d m=%b i=%0d want 1 0 3", obs_done, res_match, res_index);
    end
    res_idx_m = 5'd3;
  endtask

  task automatic test_timeout();
    run_job(1'b0, 1000, 1'b1, 5'd7);
    checks++;
    if (obs_lat != TIMEOUT) begin
      errors++; $display("FAIL timeout_latency got %0d want %0d", obs_lat, TIMEOUT);
    end
    checks++;
    if ({res_timeout, res_match, res_index} !== {1'b1, 1'b0, res_idx_m}) begin
      errors++; $display("FAIL timeout_result got t=%b m=%b i=%0d want t=1 m=0 i=%0d", res_timeout, res_match, res_index, res_idx_m);
    end
    checks++;
    if (obs_done != 1) begin
      errors++; $display("FAIL timeout_done got %0d pulses want 1", obs_done);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      int sl, pl, idx, dly, exp_lat;
      bit s, m, exp_to;
      logic [4:0] mi;
      logic [7:0] es[$];
      clr_bufs();
      sl = $urandom_range(1, STR_MAX);
      pl = $urandom_range(1, 3);
      for (int i = 0; i < sl; i++) put_str(8'($urandom_range(97, 99)));
      for (int i = 0; i < pl; i++) put_pat(8'($urandom_range(97, 99)));
      s = 1'($urandom_range(0, 1));
      idx = find_pat();
      m = (idx >= 0);
      mi = m ? 5'(idx) : 5'($urandom);
      dly = $urandom_range(1, 80);
      exp_to = (dly > TIMEOUT);
      exp_lat = exp_to ? TIMEOUT : dly;
      run_job(s, dly, m, mi);
      if (s) es = str_m; else es.delete();
      checks++;
      if (seq_diff(obs_s, es) != 0 || seq_diff(obs_p, pat_m) != 0) begin
        errors++; $display("FAIL b2b_stream job %0d got s=%p p=%p want s=%p p=%p", k, obs_s, obs_p, es, pat_m);
      end
      checks++;
      if (obs_excl != 0 || obs_zero != 0) begin
        errors++; $display("FAIL b2b_flags job %0d got both=%0d nonzero=%0d want 0 0", k, obs_excl, obs_zero);
      end
      checks++;
      if (obs_lat != exp_lat || obs_done != 1) begin
        errors++; $display("FAIL b2b_latency job %0d got %0d/%0d want %0d/1", k, obs_lat, obs_done, exp_lat);
      end
      if (!exp_to) res_idx_m = mi;
      checks++;
      if ({res_timeout, res_match, res_index} !== {exp_to, (m && !exp_to), res_idx_m}) begin
        errors++; $display("FAIL b2b_result job %0d got t=%b m=%b i=%0d want t=%b m=%b i=%0d",
                           k, res_timeout, res_match, res_index, exp_to, (m && !exp_to), res_idx_m);
      end
    end
  endtask

  task automatic test_busy_writes();
    clr_bufs();
    for (int i = 0; i < 4; i++) put_str(8'($urandom_range(97, 122)));
    for (int i = 0; i < 2; i++) put_pat(8'($urandom_range(97, 122)));
    start = 1'b1; send_str = 1'b1;
    tick();
    start = 1'b0; send_str = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wr_str = 1'($urandom_range(0, 1)); wr_pat = 1'($urandom_range(0, 1));
      buf_clr = 1'($urandom_range(0, 1)); wdata = 8'($urandom);
      tick();
    end
    wr_str = 1'b0; wr_pat = 1'b0; buf_clr = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busywr_busy got %b want 1", busy);
    end
    for (int i = 0; i < 150 && !done; i++) tick();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL busywr_wait_done got %b want 1", done);
    end
    tick();
    run_job(1'b1, 2, 1'b0, 5'd9);
    res_idx_m = 5'd9;
    checks++;
    if (seq_diff(obs_s, str_m) != 0 || seq_diff(obs_p, pat_m) != 0) begin
      errors++; $display("FAIL busywr_lengths got %0d/%0d want %0d/%0d", obs_s.size(), obs_p.size(), str_m.size(), pat_m.size());
    end
    checks++;
    if (err !== err_m) begin
      errors++; $display("FAIL busywr_err got %b want %b", err, err_m);
    end
  endtask

  task automatic test_reset_midjob();
    int dcount;
    bit seen;
    clr_bufs();
    for (int i = 0; i < 5; i++) put_str(8'($urandom_range(97, 122)));
    for (int i = 0; i < 4; i++) put_pat(8'($urandom_range(97, 122)));
    start = 1'b1; send_str = 1'b1;
    tick();
    start = 1'b0; send_str = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (ispattern) seen = 1'b1; else tick();
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL midrst_reach_pat got 0 want 1");
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({chardata, isstring, ispattern, busy, done, res_match, res_index, res_timeout, err} !== 20'h0) begin
      errors++;
      $display("FAIL midrst_outputs got %h want 00000",
               {chardata, isstring, ispattern, busy, done, res_match, res_index, res_timeout, err});
    end
    dcount = 0;
    repeat (2) begin
      tick();
      if (done) dcount++;
    end
    reset = 1'b1;
    repeat (6) begin
      tick();
      if (done || busy) dcount++;
    end
    checks++;
    if (dcount != 0) begin
      errors++; $display("FAIL midrst_no_done got %0d active cycles want 0", dcount);
    end
    str_m.delete(); pat_m.delete(); err_m = 1'b0; res_idx_m = 5'd0;
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < STR_MAX + 1; i++) put_str(8'($urandom_range(65, 90)));
    checks++;
    if (err !== err_m || err_m !== 1'b1) begin
      errors++; $display("FAIL ovf_err got %b want 1", err);
    end
    put_pat(8'h41);
    clr_bufs();
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL ovf_err_sticky got %b want 1", err);
    end
    for (int i = 0; i < STR_MAX + 1; i++) put_str(8'($urandom_range(65, 90)));
    put_pat(8'h41);
    run_job(1'b1, 5, 1'b0, 5'd0);
    checks++;
    if (seq_diff(obs_s, str_m) != 0 || obs_s.size() != STR_MAX) begin
      errors++; $display("FAIL ovf_str_len got %0d want %0d", obs_s.size(), STR_MAX);
    end
    apply_reset();
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL ovf_err_reset got %b want 0", err);
    end
    start = 1'b1; send_str = 1'b0;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if ({busy, ispattern, isstring, err} !== 4'b0001) begin
      errors++; $display("FAIL ovf_empty_start got b=%b p=%b s=%b e=%b want 0 0 0 1", busy, ispattern, isstring, err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pattern_only();
    test_timeout();
    test_back_to_back();
    test_busy_writes();
    test_reset_midjob();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sme_driver.md
SME_DRIVER -- requirements
Module: sme_driver

Interface
REQ-001 SHALL have parameter STR_MAX, default 32, meaning string buffer depth in characters.
REQ-002 SHALL have parameter PAT_MAX, default 8, meaning pattern buffer depth in characters.
REQ-003 SHALL have parameter TIMEOUT, default 64, meaning maximum cycles to wait for valid.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_str  input  1  appends wdata to the string buffer.
REQ-007 SHALL have port wr_pat  input  1  appends wdata to the pattern buffer.
REQ-008 SHALL have port wdata  input  8  character being loaded.
REQ-009 SHALL have port buf_clr  input  1  empties both buffers.
REQ-010 SHALL have port start  input  1  requests one match job.
REQ-011 SHALL have port send_str  input  1  sampled with start: 1 = resend the string, 0 = pattern only.
REQ-012 SHALL have port valid  input  1  engine result strobe.
REQ-013 SHALL have port match  input  1  engine match flag.
REQ-014 SHALL have port match_index  input  5  engine match position.
REQ-015 SHALL have port chardata  output  8  character to the engine.
REQ-016 SHALL have port isstring  output  1  chardata is a string character.
REQ-017 SHALL have port ispattern  output  1  chardata is a pattern character.
REQ-018 SHALL have port busy  output  1  a job is in progress.
REQ-019 SHALL have port done  output  1  one-cycle job-complete pulse.
REQ-020 SHALL have port res_match  output  1  captured match result.
REQ-021 SHALL have port res_index  output  5  captured match_index.
REQ-022 SHALL have port res_timeout  output  1  the job ended without valid.
REQ-023 SHALL have port err  output  1  sticky flag: overflow write or rejected start.

Function
REQ-024 SHALL implement FSM states IDLE, SEND_STR, SEND_PAT, WAIT and DONE.
REQ-025 SHALL, in IDLE, accept start only when pat_len>0 and (send_str=0 or str_len>0); otherwise SHALL ignore start and set err.
REQ-026 SHALL, on a start accepted at edge N, enter SEND_STR (send_str=1) or SEND_PAT (send_str=0); the first character is on chardata after edge N.
REQ-027 SHALL, in SEND_STR, drive isstring=1 and string characters 0..str_len-1 on consecutive cycles, then go directly to SEND_PAT with no gap.
REQ-028 SHALL, in SEND_PAT, drive ispattern=1 and pattern characters 0..pat_len-1 on consecutive cycles, then enter WAIT.
REQ-029 SHALL keep isstring and ispattern mutually exclusive, and SHALL drive chardata=8'h00 whenever both are low; all three outputs SHALL be registered.
REQ-030 SHALL, in WAIT, capture match and match_index into res_match and res_index on the first cycle valid=1, then enter DONE.
REQ-031 SHALL, in WAIT, count cycles; at TIMEOUT cycles without valid it SHALL set res_timeout=1 and res_match=0, then enter DONE.
REQ-032 SHALL, in DONE, pulse done for exactly one cycle, then return to IDLE; a new start is accepted on the following cycle at the earliest.
REQ-033 SHALL hold busy=1 in every state except IDLE.
REQ-034 SHALL clear res_timeout at each accepted start; res_match and res_index SHALL hold until the next capture.
REQ-035 SHALL accept buffer writes and buf_clr only in IDLE, and SHALL ignore them while busy.
REQ-036 SHALL ignore a write to a full buffer (str_len=STR_MAX or pat_len=PAT_MAX) and set err.
REQ-037 SHALL give priority to buf_clr when it is asserted together with a write.
REQ-038 SHALL clear err only by reset.
REQ-039 SHALL keep buffer contents after a job, so that pattern-only jobs reuse the engine's stored string.
REQ-040 SHALL ignore valid outside WAIT.

Reset
REQ-041 SHALL, on reset low, immediately enter IDLE and set outputs to chardata=0, isstring=0, ispattern=0, busy=0, done=0, res_match=0, res_index=0, res_timeout=0, err=0, with str_len=0 and pat_len=0.
REQ-042 SHALL abandon a job when reset is asserted mid-job; no done pulse is produced.

Structure
REQ-043 SHALL place the FSM state encoding and the STR_MAX, PAT_MAX and TIMEOUT defaults in shared package sme_pkg.
REQ-044 SHALL implement both buffers as two instances of sub-module sme_char_buf (parameterised depth, write-append, indexed read, length, full, clear).

Verification
REQ-045 SHALL verify: load "ab" as the string and "b" as the pattern, start with send_str=1 -> isstring high 2 cycles (0x61, 0x62), then ispattern high 1 cycle (0x62); engine valid with index 1 -> res_match=1, res_index=1, one done pulse.
REQ-046 SHALL verify: start with send_str=0 and pat_len=3 -> no isstring cycle, ispattern high exactly 3 cycles.
REQ-047 SHALL verify: valid held low with TIMEOUT=64 -> done exactly 64 cycles after WAIT entry, res_timeout=1, res_match=0.
REQ-048 SHALL verify: 33 string writes with STR_MAX=32 -> str_len=32 and err=1; start with pat_len=0 -> stays IDLE and err=1.
REQ-049 SHALL verify: reset pulled low during SEND_PAT -> outputs at reset values immediately, and no done pulse.
REQ-050 SHALL verify: writes and buf_clr while busy -> buffer lengths unchanged.
